// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 4
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one add/shift iteration per clock
// through a single n_bit_adder, start/busy/done handshake.
module shift_add_multiplier #(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   sum_s;
    logic           sum_c;

    assign add_b = q_q[0] ? m_q : '0;

    n_bit_adder #(.N(N)) u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum_s),
        .cout (sum_c)
    );

    // Next-state and datapath; busy/done are the registered view of the next state.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = CALC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Right shift of {cout, s, q}: the carry lands in acc's MSB.
                acc_d   = {sum_c, sum_s[N-1:1]};
                q_d     = {sum_s[0], q_q[N-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = {sum_c, sum_s, q_q[N-1:1]};
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// Ripple adder used as the multiplier's single arithmetic resource.
module n_bit_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    assign {cout, s} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
endmodule
